// File: rtl/fp16_acc_sequencer.sv
// ---------------------------------------------------------------------------
// fp16_acc_sequencer
//
// Purpose:
//   Initiator side of the fp16_adder start/valid/clear handshake. Takes a
//   stream of FP16 operands that make up one vector (terminated by in_last)
//   and folds them into a running sum. Each operand after the first costs
//   one addition on the external adder. The final sum is then offered
//   downstream. Used for neuron dot-product reduction between the NPU
//   operand buffer and the adder.
//
// Parameters:
//   GAP_CYCLES     - idle cycles after add_clear before the next add_start (0 ok)
//   TIMEOUT_CYCLES - max cycles waiting for add_valid before abort (>=1)
//   CNT_W          - width of the saturating element counter
//
// Ports:
//   clk, reset_b           - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      - operand handshake; in_data FP16 operand, in_last ends vector
//   out_valid/out_ready    - result handshake; out_data FP16 sum
//   out_count              - elements accepted for this vector (saturating)
//   err_timeout            - sticky flag, an addition timed out (cleared by reset only)
//   add_start, add_clear   - control pulses to fp16_adder
//   add_a, add_b           - adder operands (held stable while waiting)
//   add_result, add_valid  - adder response
//
// Optional feature (macro FP16_ACC_ZERO_SKIP_EN):
//   When defined, a +/-0 operand arriving after the first element skips the
//   adder entirely; the accumulator is left alone and the count still moves.
// ---------------------------------------------------------------------------
module fp16_acc_sequencer #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             err_timeout,
  output logic             add_start,
  output logic             add_clear,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_result,
  input  logic             add_valid
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    EMPTY,
    HAVE_ACC,
    START,
    WAIT,
    CLEAR,
    GAP,
    DONE
  } stateT;

  stateT            state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [15:0]      opnd_q, opnd_d;
  logic             lastPend_q, lastPend_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             err_q, err_d;
  logic             rdy_q;

  logic             xfer;
  logic [CNT_W-1:0] countInc;
  stateT            postGap;

  // rdy_q keeps in_ready low while reset is held, so every output reads 0
  // during reset even though EMPTY is normally a ready state.
  assign xfer     = in_valid & in_ready;
  assign countInc = (&count_q) ? count_q : count_q + 1'b1;
  assign postGap  = lastPend_q ? DONE : HAVE_ACC;

  assign out_data    = acc_q;
  assign out_count   = count_q;
  assign err_timeout = err_q;
  assign add_a       = acc_q;
  assign add_b       = opnd_q;

  // State and datapath registers; everything returns to zero / EMPTY on reset.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= EMPTY;
      acc_q      <= '0;
      opnd_q     <= '0;
      lastPend_q <= 1'b0;
      count_q    <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      lastPend_q <= lastPend_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      rdy_q      <= 1'b1;
    end
  end

  // Next-state and output decode. The accumulator only changes on the first
  // operand or when the adder answers; a timeout drops the operand.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    lastPend_d = lastPend_q;
    count_d    = count_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    err_d      = err_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_start  = 1'b0;
    add_clear  = 1'b0;

    case (state_q)
      EMPTY: begin
        in_ready = rdy_q;
        if (xfer) begin
          acc_d   = in_data;
          count_d = CNT_W'(1);
          state_d = in_last ? DONE : HAVE_ACC;
        end
      end
      HAVE_ACC: begin
        in_ready = rdy_q;
        if (xfer) begin
          count_d    = countInc;
          lastPend_d = in_last;
`ifdef FP16_ACC_ZERO_SKIP_EN
          if (in_data[14:0] == 15'd0) begin
            state_d = in_last ? DONE : HAVE_ACC;
          end else begin
            opnd_d  = in_data;
            state_d = START;
          end
`else
          opnd_d  = in_data;
          state_d = START;
`endif
        end
      end
      START: begin
        add_start = 1'b1;
        tmo_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (add_valid) begin
          acc_d   = add_result;
          state_d = CLEAR;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = CLEAR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CLEAR: begin
        add_clear = 1'b1;
        gap_d     = '0;
        state_d   = (GAP_CYCLES > 0) ? GAP : postGap;
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = postGap;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          count_d = '0;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_fp16_acc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fp16_acc_sequencer
//
// Directed-vector bench for fp16_acc_sequencer with a behavioural adder stub
// (valid 3 cycles after start, held until clear). Expected sums are pushed
// into a scoreboard queue as each vector is issued; a monitor pops and
// compares whenever the DUT completes an output handshake.
// ---------------------------------------------------------------------------
module tb_fp16_acc_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_b;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             err_timeout;
  logic             add_start;
  logic             add_clear;
  logic [15:0]      add_a;
  logic [15:0]      add_b;
  logic [15:0]      add_result;
  logic             add_valid;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  count;
  } expT;

  expT         expQ[$];
  int          checks = 0;
  int          fails = 0;
  int          startCount = 0;
  int          clearCount = 0;
  logic [15:0] lastA = '0;
  logic [15:0] lastB = '0;
  bit          neverValid = 1'b0;

  logic        busy;
  logic [1:0]  lat;
  logic [15:0] capA, capB;

  fp16_acc_sequencer #(
    .GAP_CYCLES    (2),
    .TIMEOUT_CYCLES(64),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .err_timeout(err_timeout),
    .add_start  (add_start),
    .add_clear  (add_clear),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .add_valid  (add_valid)
  );

  always #5 clk = ~clk;

  // Hand-computed FP16 sums for the operand pairs the vectors produce.
  function automatic logic [15:0] fakeAdd(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] pair;
    pair = {a, b};
    if (b[14:0] == 15'd0) return a;
    case (pair)
      32'h3C00_4000: return 16'h4200;
      32'h4000_3C00: return 16'h4200;
      32'h3C00_3C00: return 16'h4000;
      32'h4200_3C00: return 16'h4400;
      default:       return 16'h7E00;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural adder: latches operands on start, raises valid two edges
  // later (third cycle), holds it until clear. neverValid models a hung adder.
  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      add_valid  <= 1'b0;
      add_result <= '0;
      busy       <= 1'b0;
      lat        <= '0;
      capA       <= '0;
      capB       <= '0;
    end else if (add_clear) begin
      add_valid <= 1'b0;
      busy      <= 1'b0;
      lat       <= '0;
    end else if (add_start) begin
      busy <= 1'b1;
      capA <= add_a;
      capB <= add_b;
      lat  <= 2'd2;
    end else if (busy && lat != 2'd0) begin
      lat <= lat - 2'd1;
      if (lat == 2'd1 && !neverValid) begin
        add_valid  <= 1'b1;
        add_result <= fakeAdd(capA, capB);
      end
    end
  end

  // Monitor: protocol checks on the adder side and scoreboard pop on each
  // completed output handshake.
  always @(negedge clk) begin
    if (reset_b) begin
      if (add_start) begin
        startCount++;
        lastA = add_a;
        lastB = add_b;
        checkOutput("startWhileValid", 32'(add_valid), 32'd0);
      end
      if (add_clear) clearCount++;
      if (busy && !add_clear) begin
        checkOutput("addAStable", 32'(add_a), 32'(capA));
        checkOutput("addBStable", 32'(add_b), 32'(capB));
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOutput", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          expT e;
          e = expQ.pop_front();
          checkOutput("sumData", 32'(out_data), 32'(e.data));
          checkOutput("sumCount", 32'(out_count), 32'(e.count));
        end
      end
    end
  end

  // Offers one operand, waits for the transfer, and for non-last operands
  // counts cycles with in_ready low afterwards.
  task automatic applyStimulus(input logic [15:0] d, input bit last, output int lowCycles);
    int n;
    lowCycles = 0;
    @(negedge clk);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("inReadyTimeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!last) begin
      @(negedge clk);
      while (!in_ready && lowCycles < 300) begin
        lowCycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic waitOutput();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("outValidSeen", 32'(out_valid), 32'd1);
    @(negedge clk);
  endtask

  task automatic waitAddStart();
    int n;
    n = 0;
    @(negedge clk);
    while (!add_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("addStartSeen", 32'(add_start), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int low, s0, c0, e;
    reset_b   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutCount", 32'(out_count), 32'd0);
    checkOutput("rstOutData", 32'(out_data), 32'd0);
    checkOutput("rstErr", 32'(err_timeout), 32'd0);
    checkOutput("rstAddStart", 32'(add_start), 32'd0);
    checkOutput("rstAddClear", 32'(add_clear), 32'd0);
    reset_b = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterRst", 32'(in_ready), 32'd1);

    // 1.0 + 2.0
    $display("[TB] vector: 1.0 + 2.0");
    s0 = startCount; c0 = clearCount;
    expQ.push_back({16'h4200, 8'd2});
    applyStimulus(16'h3C00, 1'b0, low);
    checkOutput("firstOpNoStall", 32'(low), 32'd0);
    applyStimulus(16'h4000, 1'b1, low);
    waitOutput();
    checkOutput("pairStarts", 32'(startCount - s0), 32'd1);
    checkOutput("pairClears", 32'(clearCount - c0), 32'd1);
    checkOutput("pairAddA", 32'(lastA), 32'h3C00);
    checkOutput("pairAddB", 32'(lastB), 32'h4000);

    // Four ones
    $display("[TB] vector: four x 1.0");
    s0 = startCount; c0 = clearCount;
    expQ.push_back({16'h4400, 8'd4});
    applyStimulus(16'h3C00, 1'b0, low);
    applyStimulus(16'h3C00, 1'b0, low);
    checkOutput("op2StallCycles", 32'(low), 32'd7);
    applyStimulus(16'h3C00, 1'b0, low);
    checkOutput("op3StallCycles", 32'(low), 32'd7);
    applyStimulus(16'h3C00, 1'b1, low);
    waitOutput();
    checkOutput("fourStarts", 32'(startCount - s0), 32'd3);
    checkOutput("fourClears", 32'(clearCount - c0), 32'd3);

    // Single element
    $display("[TB] vector: single -5.0");
    s0 = startCount;
    expQ.push_back({16'hC500, 8'd1});
    applyStimulus(16'hC500, 1'b1, low);
    @(negedge clk);
    checkOutput("singleValidNext", 32'(out_valid), 32'd1);
    @(negedge clk);
    checkOutput("singleNoStart", 32'(startCount - s0), 32'd0);

    // Back-pressure in DONE
    $display("[TB] vector: held output");
    out_ready = 1'b0;
    expQ.push_back({16'h4200, 8'd2});
    applyStimulus(16'h3C00, 1'b0, low);
    applyStimulus(16'h4000, 1'b1, low);
    e = 0;
    @(negedge clk);
    while (!out_valid && e < 100) begin
      @(negedge clk);
      e++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("holdValid", 32'(out_valid), 32'd1);
      checkOutput("holdData", 32'(out_data), 32'h4200);
      checkOutput("holdInReady", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("releaseInReady", 32'(in_ready), 32'd1);
    checkOutput("releaseCount", 32'(out_count), 32'd0);
    checkOutput("releaseValid", 32'(out_valid), 32'd0);

    // Adder timeout
    $display("[TB] vector: adder timeout");
    neverValid = 1'b1;
    s0 = startCount; c0 = clearCount;
    expQ.push_back({16'h3C00, 8'd2});
    applyStimulus(16'h3C00, 1'b0, low);
    applyStimulus(16'h4000, 1'b1, low);
    waitAddStart();
    checkOutput("errBeforeTimeout", 32'(err_timeout), 32'd0);
    e = 0;
    do begin
      @(negedge clk);
      e++;
    end while (!err_timeout && e < 200);
    checkOutput("timeoutLatency", 32'(e), 32'd65);
    checkOutput("timeoutClear", 32'(add_clear), 32'd1);
    neverValid = 1'b0;
    waitOutput();
    checkOutput("timeoutStarts", 32'(startCount - s0), 32'd1);
    checkOutput("timeoutClears", 32'(clearCount - c0), 32'd1);

    // Sticky error survives the next vector
    expQ.push_back({16'h4000, 8'd1});
    applyStimulus(16'h4000, 1'b1, low);
    waitOutput();
    checkOutput("errSticky", 32'(err_timeout), 32'd1);

    // Negative zero operand
    $display("[TB] vector: 1.0 + -0");
    s0 = startCount;
    expQ.push_back({16'h3C00, 8'd2});
    applyStimulus(16'h3C00, 1'b0, low);
    applyStimulus(16'h8000, 1'b1, low);
    waitOutput();
`ifdef FP16_ACC_ZERO_SKIP_EN
    checkOutput("zeroStarts", 32'(startCount - s0), 32'd0);
`else
    checkOutput("zeroStarts", 32'(startCount - s0), 32'd1);
`endif

    // Count saturation
    $display("[TB] vector: 260 zeros");
    expQ.push_back({16'h0000, 8'd255});
    for (int i = 0; i < 260; i++) begin
      applyStimulus(16'h0000, (i == 259), low);
    end
    waitOutput();

    // Reset while waiting on the adder
    $display("[TB] vector: reset during WAIT");
    applyStimulus(16'h3C00, 1'b0, low);
    applyStimulus(16'h4000, 1'b1, low);
    waitAddStart();
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    checkOutput("midRstAddStart", 32'(add_start), 32'd0);
    checkOutput("midRstAddClear", 32'(add_clear), 32'd0);
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstInReady", 32'(in_ready), 32'd0);
    checkOutput("midRstErr", 32'(err_timeout), 32'd0);
    checkOutput("midRstCount", 32'(out_count), 32'd0);
    expQ.delete();
    repeat (2) @(negedge clk);
    reset_b = 1'b1;

    // Recovery
    expQ.push_back({16'h4200, 8'd2});
    applyStimulus(16'h4000, 1'b0, low);
    applyStimulus(16'h3C00, 1'b1, low);
    waitOutput();

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
